// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the CPU data-memory responder.
//   - region_e       : address decode result (RAM, MMIO window, unmapped)
//   - OFS_*          : word offsets inside the 16-byte MMIO window (Adr[3:2])
//   - STATUS_*       : bit positions of the MMIO STATUS word
//   - MMIO_BASE_DEFAULT : default byte base of the MMIO window
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      REGION_RAM  = 2'd0,
      REGION_MMIO = 2'd1,
      REGION_NONE = 2'd2
   } region_e;

   localparam logic [1:0] OFS_OUT    = 2'd0;
   localparam logic [1:0] OFS_STATUS = 2'd1;
   localparam logic [1:0] OFS_CYCLE  = 2'd2;
   localparam logic [1:0] OFS_DROPS  = 2'd3;

   localparam int unsigned STATUS_FULL_BIT  = 0;
   localparam int unsigned STATUS_EMPTY_BIT = 1;
   localparam int unsigned STATUS_COUNT_LSB = 4;
   localparam int unsigned STATUS_COUNT_W   = 4;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/data_mem_responder_fifo.sv
// Synchronous circular-buffer FIFO used for the MMIO output stream.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write request and data
//   pop             : read request (ignored while empty)
//   head_data       : entry at the read pointer, 0 while empty
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
//   dropped         : push this cycle was refused (full with no pop)
// A push into a full FIFO is accepted when a pop happens in the same cycle,
// so the pushed word lands behind the remaining entries and count holds.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             dropped
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dropped = push & ~do_push;

   assign head_data = empty ? '0 : mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer increments wrap on their own.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; empty flag masks stale entries.
   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: word RAM plus a 16-byte MMIO
// window (output FIFO, STATUS, free-running CYCLE counter, DROPS counter).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   MemWrite    : store strobe for this cycle
//   Adr         : byte address (low two bits ignored)
//   WriteData   : store data
//   ReadData    : load data, combinational, shows state before this edge
//   OutData     : FIFO head word (0 while empty)
//   OutValid    : FIFO non-empty
//   OutReady    : consumer takes the head when OutValid & OutReady
//   Err         : sticky flag, set by any store to an unmapped address
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [31:0] OutData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic        Err
);

   localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
   localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH + 1);

   region_e             region;
   logic [RAM_AW-1:0]   ram_idx;
   logic [1:0]          mmio_ofs;
   logic                unused_adr_lsbs;

   logic [31:0]         ram_q [RAM_WORDS];
   logic                ram_we;

   logic [31:0]         cycle_q, cycle_d;
   logic [31:0]         drops_q, drops_d;
   logic                err_q, err_d;

   logic                fifo_push;
   logic                fifo_full;
   logic                fifo_empty;
   logic [FIFO_CW-1:0]  fifo_count;
   logic                fifo_dropped;
   logic [31:0]         status_word;

   logic                mmio_we;

   assign unused_adr_lsbs = ^Adr[1:0];
   assign ram_idx  = Adr[RAM_AW+1:2];
   assign mmio_ofs = Adr[3:2];

   // RAM is checked first so an overlapping MMIO_BASE cannot shadow RAM.
   always_comb begin
      region = REGION_NONE;
      if (Adr[31:RAM_AW+2] == '0) begin
         region = REGION_RAM;
      end else if (Adr[31:4] == MMIO_BASE[31:4]) begin
         region = REGION_MMIO;
      end
   end

   assign ram_we    = MemWrite & (region == REGION_RAM);
   assign mmio_we   = MemWrite & (region == REGION_MMIO);
   assign fifo_push = mmio_we & (mmio_ofs == OFS_OUT);

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (WriteData),
      .pop       (OutReady),
      .head_data (OutData),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .dropped   (fifo_dropped)
   );

   assign OutValid = ~fifo_empty;
   assign Err      = err_q;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_idx] <= WriteData;
      end
   end

   always_comb begin
      cycle_d = cycle_q + 32'd1;
      drops_d = drops_q;
      err_d   = err_q;
      if (mmio_we && (mmio_ofs == OFS_CYCLE)) begin
         cycle_d = '0;
      end
      if (mmio_we && (mmio_ofs == OFS_DROPS)) begin
         drops_d = '0;
      end else if (fifo_dropped && (drops_q != 32'hFFFF_FFFF)) begin
         drops_d = drops_q + 32'd1;
      end
      if (MemWrite && (region == REGION_NONE)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
         drops_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cycle_q <= cycle_d;
         drops_q <= drops_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      status_word = '0;
      status_word[STATUS_FULL_BIT]  = fifo_full;
      status_word[STATUS_EMPTY_BIT] = fifo_empty;
      status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
   end

   always_comb begin
      ReadData = '0;
      unique case (region)
         REGION_RAM: ReadData = ram_q[ram_idx];
         REGION_MMIO: begin
            unique case (mmio_ofs)
               OFS_STATUS: ReadData = status_word;
               OFS_CYCLE:  ReadData = cycle_q;
               OFS_DROPS:  ReadData = drops_q;
               default:    ReadData = '0;
            endcase
         end
         default: ReadData = '0;
      endcase
   end

endmodule
